// File: rtl/i2c_slave_regfile_controller_if.sv
// Byte-engine and register-file signal bundle for i2c_slave_regfile_controller.
interface i2c_slave_regfile_controller_if #(
  parameter int unsigned REG_COUNT_LOG2 = 5
) ();
  logic                      Slave_AddrMatch;
  logic                      Slave_RW;
  logic                      Slave_ByteRcvd;
  logic [7:0]                Slave_RxData;
  logic                      Slave_TxReq;
  logic                      Slave_StopDet;
  logic                      Slave_ACK;
  logic [7:0]                Slave_TxData;
  logic                      Slave_TxValid;
  logic [REG_COUNT_LOG2-1:0] RAM_ADD;
  logic [7:0]                RAM_DIN;
  logic                      RAM_W;
  logic [7:0]                RAM_RDOUT;

  modport slave (
    input  Slave_AddrMatch, Slave_RW, Slave_ByteRcvd, Slave_RxData, Slave_TxReq, Slave_StopDet,
    input  RAM_RDOUT,
    output Slave_ACK, Slave_TxData, Slave_TxValid, RAM_ADD, RAM_DIN, RAM_W
  );

  modport master (
    output Slave_AddrMatch, Slave_RW, Slave_ByteRcvd, Slave_RxData, Slave_TxReq, Slave_StopDet,
    output RAM_RDOUT,
    input  Slave_ACK, Slave_TxData, Slave_TxValid, RAM_ADD, RAM_DIN, RAM_W
  );
endinterface

// File: rtl/i2c_slave_regfile_controller.sv
// I2C slave register-file controller: pointer write, auto-increment burst write/read.
// Optional I2C_SLAVE_WRITE_PROTECT_EN adds a Write_Protect input gating data writes.
module i2c_slave_regfile_controller #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'b1100111,
  parameter int unsigned REG_COUNT_LOG2 = 5
) (
  input  logic clk,
  input  logic reset,
  i2c_slave_regfile_controller_if.slave bus,
  output logic Slave_Busy,
  output logic Transaction_Done
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
  ,
  input  logic Write_Protect
`endif
);

  typedef enum logic [2:0] {
    StIdle, StGetRegaddr, StWriteData, StReadFetch, StReadPresent, StReadWait
  } state_e;

  state_e state_q, state_d;

  logic [REG_COUNT_LOG2-1:0] ptr_q, ptr_d, ram_add_q, ram_add_d;
  logic [7:0] ram_din_q, ram_din_d, tx_data_q, tx_data_d;
  logic ram_w_q, ram_w_d, ack_q, ack_d, tx_valid_q, tx_valid_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [7:0] upper_bits;
  logic addr_ok, restart, wp;

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
  assign wp = Write_Protect;
`else
  assign wp = 1'b0;
`endif

  assign upper_bits = bus.Slave_RxData >> REG_COUNT_LOG2;
  assign addr_ok    = (upper_bits == 8'd0);
  // START/STOP override every state; per-state actions are suppressed that cycle.
  assign restart    = bus.Slave_AddrMatch | bus.Slave_StopDet;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.Slave_AddrMatch) begin
      state_d = bus.Slave_RW ? StReadWait : StGetRegaddr;
    end else if (bus.Slave_StopDet) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StGetRegaddr:  if (bus.Slave_ByteRcvd) state_d = addr_ok ? StWriteData : StIdle;
        StReadWait:    if (bus.Slave_TxReq) state_d = StReadFetch;
        StReadFetch:   state_d = StReadPresent;
        StReadPresent: state_d = StReadWait;
        default:       state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    ram_add_d  = ram_add_q;
    ram_din_d  = ram_din_q;
    tx_data_d  = tx_data_q;
    ram_w_d    = 1'b0;
    ack_d      = 1'b0;
    tx_valid_d = 1'b0;
    done_d     = bus.Slave_StopDet & busy_q;
    busy_d     = busy_q;
    if (bus.Slave_AddrMatch)    busy_d = 1'b1;
    else if (bus.Slave_StopDet) busy_d = 1'b0;
    if (!restart) begin
      unique case (state_q)
        StGetRegaddr: begin
          if (bus.Slave_ByteRcvd && addr_ok) begin
            ptr_d = bus.Slave_RxData[REG_COUNT_LOG2-1:0];
            ack_d = 1'b1;
          end
        end
        StWriteData: begin
          if (bus.Slave_ByteRcvd && !wp) begin
            ram_add_d = ptr_q;
            ram_din_d = bus.Slave_RxData;
            ram_w_d   = 1'b1;
            ack_d     = 1'b1;
            ptr_d     = ptr_q + 1'b1;
          end
        end
        StReadWait: if (bus.Slave_TxReq) ram_add_d = ptr_q;
        StReadPresent: begin
          tx_data_d  = bus.RAM_RDOUT;
          tx_valid_d = 1'b1;
          ptr_d      = ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      ram_add_q  <= '0;
      ram_din_q  <= '0;
      tx_data_q  <= '0;
      ram_w_q    <= 1'b0;
      ack_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ram_add_q  <= ram_add_d;
      ram_din_q  <= ram_din_d;
      tx_data_q  <= tx_data_d;
      ram_w_q    <= ram_w_d;
      ack_q      <= ack_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.Slave_ACK     = ack_q;
  assign bus.Slave_TxData  = tx_data_q;
  assign bus.Slave_TxValid = tx_valid_q;
  assign bus.RAM_ADD       = ram_add_q;
  assign bus.RAM_DIN       = ram_din_q;
  assign bus.RAM_W         = ram_w_q;
  assign Slave_Busy        = busy_q;
  assign Transaction_Done  = done_q;

endmodule

// File: tb/tb_i2c_slave_regfile_controller.sv
// Directed self-checking bench for i2c_slave_regfile_controller with a synchronous RAM model.
module tb_i2c_slave_regfile_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, done;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] mem [32];

  always #5 clk = ~clk;

  i2c_slave_regfile_controller_if #(.REG_COUNT_LOG2(5)) bus ();

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
  logic wp = 1'b0;
`endif

  i2c_slave_regfile_controller #(
    .SLAVE_ADDR(7'b1100111),
    .REG_COUNT_LOG2(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .Slave_Busy(busy),
    .Transaction_Done(done)
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
    ,
    .Write_Protect(wp)
`endif
  );

  always @(posedge clk) begin
    if (bus.RAM_W) mem[bus.RAM_ADD] <= bus.RAM_DIN;
    bus.RAM_RDOUT <= mem[bus.RAM_ADD];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic rw, input logic with_stop);
    bus.Slave_AddrMatch = 1'b1;
    bus.Slave_RW        = rw;
    bus.Slave_StopDet   = with_stop;
    tick();
    bus.Slave_AddrMatch = 1'b0;
    bus.Slave_RW        = 1'b0;
    bus.Slave_StopDet   = 1'b0;
  endtask

  task automatic wbyte(input string tag, input logic [7:0] b, input logic exp_ack,
                       input logic exp_w, input logic [4:0] exp_add);
    bus.Slave_ByteRcvd = 1'b1;
    bus.Slave_RxData   = b;
    tick();
    bus.Slave_ByteRcvd = 1'b0;
    check({tag, ".ack"}, 32'(bus.Slave_ACK), 32'(exp_ack));
    check({tag, ".ramw"}, 32'(bus.RAM_W), 32'(exp_w));
    if (exp_w) begin
      check({tag, ".add"}, 32'(bus.RAM_ADD), 32'(exp_add));
      check({tag, ".din"}, 32'(bus.RAM_DIN), 32'(b));
    end
  endtask

  task automatic stop(input string tag, input logic exp_done);
    bus.Slave_StopDet = 1'b1;
    tick();
    bus.Slave_StopDet = 1'b0;
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".busy"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".done_clr"}, 32'(done), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    bus.Slave_TxReq = 1'b1;
    tick();
    bus.Slave_TxReq = 1'b0;
    check({tag, ".v1"}, 32'(bus.Slave_TxValid), 32'd0);
    tick();
    check({tag, ".v2"}, 32'(bus.Slave_TxValid), 32'd0);
    tick();
    check({tag, ".v3"}, 32'(bus.Slave_TxValid), 32'd1);
    check({tag, ".data"}, 32'(bus.Slave_TxData), 32'(exp));
    tick();
    check({tag, ".v4"}, 32'(bus.Slave_TxValid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ack"}, 32'(bus.Slave_ACK), 32'd0);
    check({tag, ".txv"}, 32'(bus.Slave_TxValid), 32'd0);
    check({tag, ".txd"}, 32'(bus.Slave_TxData), 32'd0);
    check({tag, ".ramw"}, 32'(bus.RAM_W), 32'd0);
    check({tag, ".add"}, 32'(bus.RAM_ADD), 32'd0);
    check({tag, ".din"}, 32'(bus.RAM_DIN), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
  endtask

  initial begin
    bus.Slave_AddrMatch = 1'b0;
    bus.Slave_RW        = 1'b0;
    bus.Slave_ByteRcvd  = 1'b0;
    bus.Slave_RxData    = 8'h00;
    bus.Slave_TxReq     = 1'b0;
    bus.Slave_StopDet   = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Basic burst write with pointer
    addr(1'b0, 1'b0);
    check("w1.busy", 32'(busy), 32'd1);
    wbyte("w1.p", 8'h05, 1'b1, 1'b0, 5'd0);
    wbyte("w1.d0", 8'hA1, 1'b1, 1'b1, 5'd5);
    wbyte("w1.d1", 8'hB2, 1'b1, 1'b1, 5'd6);
    stop("w1", 1'b1);
    check("w1.mem5", 32'(mem[5]), 32'h0000_00A1);
    check("w1.mem6", 32'(mem[6]), 32'h0000_00B2);

    // Pointer wrap 31 -> 0
    addr(1'b0, 1'b0);
    wbyte("wrap.p", 8'h1F, 1'b1, 1'b0, 5'd0);
    wbyte("wrap.d0", 8'h11, 1'b1, 1'b1, 5'd31);
    wbyte("wrap.d1", 8'h22, 1'b1, 1'b1, 5'd0);
    stop("wrap", 1'b1);
    check("wrap.mem31", 32'(mem[31]), 32'h0000_0011);
    check("wrap.mem0", 32'(mem[0]), 32'h0000_0022);

    // Preload RAM[3], RAM[4]; pointer ends at 5
    addr(1'b0, 1'b0);
    wbyte("pre.p", 8'h03, 1'b1, 1'b0, 5'd0);
    wbyte("pre.d0", 8'h5A, 1'b1, 1'b1, 5'd3);
    wbyte("pre.d1", 8'hC3, 1'b1, 1'b1, 5'd4);
    stop("pre", 1'b1);

    // Out-of-range pointer byte is NACKed and leaves pointer at 5
    addr(1'b0, 1'b0);
    wbyte("nack.p", 8'h20, 1'b0, 1'b0, 5'd0);
    wbyte("nack.idle", 8'h99, 1'b0, 1'b0, 5'd0);
    stop("nack", 1'b1);

    // Read without pointer write continues from retained pointer (5)
    addr(1'b1, 1'b0);
    check("ret.busy", 32'(busy), 32'd1);
    rd("ret.r0", 8'hA1);
    wbyte("ret.ign", 8'h55, 1'b0, 1'b0, 5'd0);
    stop("ret", 1'b1);

    // Pointer write then repeated START read
    addr(1'b0, 1'b0);
    wbyte("rs.p", 8'h03, 1'b1, 1'b0, 5'd0);
    addr(1'b1, 1'b0);
    rd("rs.r0", 8'h5A);
    rd("rs.r1", 8'hC3);
    stop("rs", 1'b1);

    // TxReq during a write is ignored
    addr(1'b0, 1'b0);
    wbyte("txign.p", 8'h10, 1'b1, 1'b0, 5'd0);
    bus.Slave_TxReq = 1'b1;
    tick();
    bus.Slave_TxReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("txign.v", 32'(bus.Slave_TxValid), 32'd0);
      tick();
    end
    stop("txign", 1'b1);

    // Repeated START while a fetch is pending abandons it
    addr(1'b1, 1'b0);
    bus.Slave_TxReq = 1'b1;
    tick();
    bus.Slave_TxReq = 1'b0;
    addr(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("abort.v", 32'(bus.Slave_TxValid), 32'd0);
      tick();
    end
    stop("abort", 1'b1);

    // Reset between TxReq and TxValid
    addr(1'b1, 1'b0);
    bus.Slave_TxReq = 1'b1;
    tick();
    bus.Slave_TxReq = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_outputs("mrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst.v", 32'(bus.Slave_TxValid), 32'd0);
      check("mrst.done", 32'(done), 32'd0);
    end
    // Pointer was cleared by reset: read from 0
    addr(1'b1, 1'b0);
    rd("mrst.r0", 8'h22);
    stop("mrst", 1'b1);

    // STOP and AddrMatch together: restart wins, Done still pulses
    addr(1'b0, 1'b0);
    addr(1'b0, 1'b1);
    check("both.done", 32'(done), 32'd1);
    check("both.busy", 32'(busy), 32'd1);
    wbyte("both.p", 8'h07, 1'b1, 1'b0, 5'd0);
    stop("both", 1'b1);

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
    addr(1'b0, 1'b0);
    wbyte("wp.pre.p", 8'h02, 1'b1, 1'b0, 5'd0);
    wbyte("wp.pre.d", 8'h66, 1'b1, 1'b1, 5'd2);
    stop("wp.pre", 1'b1);
    wp = 1'b1;
    addr(1'b0, 1'b0);
    wbyte("wp.p", 8'h02, 1'b1, 1'b0, 5'd0);
    wbyte("wp.d", 8'h77, 1'b0, 1'b0, 5'd0);
    stop("wp", 1'b1);
    wp = 1'b0;
    check("wp.mem2", 32'(mem[2]), 32'h0000_0066);
    addr(1'b1, 1'b0);
    rd("wp.r0", 8'h66);
    stop("wp.rd", 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2c_slave_regfile_controller.md
I2C_SLAVE_REGFILE_CONTROLLER -- requirements
Module: i2c_slave_regfile_controller

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1100111, the 7-bit I2C address this slave answers to.
REQ-002 SHALL have parameter REG_COUNT_LOG2, default 5, register-file address width (32 registers).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 Slave_AddrMatch  input  1  one-cycle pulse from the byte engine: START or repeated START plus address equal to SLAVE_ADDR.
REQ-006 Slave_RW  input  1  R/W bit of the matched address; valid with Slave_AddrMatch; 1 = master reads.
REQ-007 Slave_ByteRcvd  input  1  one-cycle pulse: Slave_RxData holds a received byte.
REQ-008 Slave_RxData  input  8  received byte.
REQ-009 Slave_TxReq  input  1  one-cycle pulse: engine needs the next byte to transmit.
REQ-010 Slave_StopDet  input  1  one-cycle pulse on STOP condition.
REQ-011 Slave_ACK  output  1  ACK (1) / NACK (0) decision for the byte just received; valid the cycle after Slave_ByteRcvd.
REQ-012 Slave_TxData  output  8  byte to transmit; valid while Slave_TxValid is high.
REQ-013 Slave_TxValid  output  1  one-cycle pulse: Slave_TxData is ready.
REQ-014 RAM_ADD  output  REG_COUNT_LOG2  register-file address.
REQ-015 RAM_DIN  output  8  register-file write data.
REQ-016 RAM_W  output  1  register-file write strobe, one cycle per write.
REQ-017 RAM_RDOUT  input  8  register-file read data; one-cycle latency after RAM_ADD.
REQ-018 Slave_Busy  output  1  high from Slave_AddrMatch until STOP.
REQ-019 Transaction_Done  output  1  one-cycle pulse on the cycle after Slave_StopDet while busy.

Function
REQ-020 States: IDLE, GET_REGADDR, WRITE_DATA, READ_FETCH, READ_PRESENT, READ_WAIT.
REQ-021 IDLE to GET_REGADDR on Slave_AddrMatch with Slave_RW=0; to READ_WAIT on Slave_AddrMatch with Slave_RW=1.
REQ-022 GET_REGADDR: on Slave_ByteRcvd, pointer <= RxData[REG_COUNT_LOG2-1:0].
REQ-023 In GET_REGADDR, Slave_ACK = 1 only if the upper RxData bits are zero; otherwise NACK, pointer unchanged, go to IDLE.
REQ-024 WRITE_DATA: on each Slave_ByteRcvd, RAM_ADD = pointer, RAM_DIN = RxData, RAM_W = 1 for exactly the next cycle, Slave_ACK = 1, then pointer increments.
REQ-025 READ_WAIT: on Slave_TxReq, RAM_ADD <= pointer and go to READ_FETCH.
REQ-026 READ_FETCH: wait one cycle for RAM latency, then go to READ_PRESENT.
REQ-027 READ_PRESENT: Slave_TxData <= RAM_RDOUT, Slave_TxValid pulses, pointer increments, return to READ_WAIT; Slave_TxReq-to-Slave_TxValid latency = 3 cycles.
REQ-028 The pointer wraps from 2^REG_COUNT_LOG2-1 to 0 with no error.
REQ-029 The pointer is retained across STOP, so a read without a preceding pointer write continues from the last pointer.
REQ-030 Slave_AddrMatch in any state, including mid-read or mid-write, restarts per REQ-021 (repeated START); any pending read fetch is abandoned and no Slave_TxValid is issued for it.
REQ-031 Slave_StopDet in any state goes to IDLE, clears Slave_Busy, and pulses Transaction_Done if Slave_Busy was high.
REQ-032 Slave_StopDet and Slave_AddrMatch in the same cycle: Slave_AddrMatch wins; Transaction_Done still pulses.
REQ-033 Slave_ByteRcvd in a read state, or Slave_TxReq in a write state, SHALL be ignored; Slave_ACK = 0 for the ignored byte.

Reset
REQ-034 reset low: state IDLE; pointer, RAM_ADD, RAM_DIN, Slave_TxData = 0; RAM_W, Slave_TxValid, Slave_ACK, Slave_Busy, Transaction_Done = 0.
REQ-035 reset low mid-transaction aborts it with no further RAM_W or Slave_TxValid and no Transaction_Done.

Configuration
REQ-036 Macro I2C_SLAVE_WRITE_PROTECT_EN defined: adds input Write_Protect (1 bit).
REQ-037 With the macro, when Write_Protect is high, WRITE_DATA bytes get Slave_ACK = 0, no RAM_W and no pointer increment; pointer writes in GET_REGADDR are unaffected.
REQ-038 Without the macro there is no Write_Protect port and writes are always accepted.

Verification
REQ-039 AddrMatch(RW=0), bytes 0x05, 0xA1, 0xB2, STOP -> RAM[5]=0xA1, RAM[6]=0xB2, three ACKs, Transaction_Done once.
REQ-040 Pointer write 0x1F, data 0x11, 0x22 -> RAM[31]=0x11, RAM[0]=0x22 (wrap).
REQ-041 Pointer write 0x20 -> NACK, no RAM_W, pointer unchanged.
REQ-042 Pointer write 0x03, repeated START with RW=1, two TxReq with RAM[3]=0x5A, RAM[4]=0xC3 -> TxData 0x5A then 0xC3, each 3 cycles after TxReq.
REQ-043 reset low for one cycle between a TxReq and its TxValid -> no TxValid, all outputs at reset values.
REQ-044 With I2C_SLAVE_WRITE_PROTECT_EN and Write_Protect=1: pointer 0x02, data 0x77 -> NACK on data, RAM[2] unchanged.
